// File: rtl/time_display_pkg.sv
// Shared constants for the time display scanner: display codes, digit
// positions, the 7-segment pattern table and the frame snapshot type.
package time_display_pkg;

  localparam logic [3:0] CODE_A     = 4'd10;
  localparam logic [3:0] CODE_P     = 4'd11;
  localparam logic [3:0] CODE_M     = 4'd12;
  localparam logic [3:0] CODE_BLANK = 4'd13;
  localparam logic [3:0] CODE_DASH  = 4'd14;

  // Digit positions, left to right
  localparam logic [2:0] DIG_TD1   = 3'd0;
  localparam logic [2:0] DIG_TD2   = 3'd1;
  localparam logic [2:0] DIG_HR_T  = 3'd2;
  localparam logic [2:0] DIG_HR_O  = 3'd3;
  localparam logic [2:0] DIG_MIN_T = 3'd4;
  localparam logic [2:0] DIG_MIN_O = 3'd5;
  localparam logic [2:0] DIG_SEC_T = 3'd6;
  localparam logic [2:0] DIG_SEC_O = 3'd7;

  // Active-high {g,f,e,d,c,b,a} per code; 13 and 15 are dark
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h73, 7'h37, 7'h00, 7'h40, 7'h00
  };

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [3:0] td1;
    logic [3:0] td2;
  } snap_t;

  localparam snap_t SNAP_RST = '{hours: 5'd0, minutes: 6'd0, seconds: 6'd0,
                                 td1: CODE_BLANK, td2: CODE_BLANK};

  // Binary to {tens, ones}; anything above max shows as two dashes
  function automatic logic [7:0] bcd2(input logic [5:0] v, input logic [5:0] max);
    if (v > max) return {CODE_DASH, CODE_DASH};
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

endpackage

// File: rtl/time_display_scan_seg7_decode.sv
// 4-bit display code to active-high 7-segment pattern. Pin polarity is
// handled by the caller.
import time_display_pkg::*;

module seg7_decode (
  input  logic [3:0] code_i,
  output logic [6:0] pat_o
);
  assign pat_o = SEG_TABLE[code_i];
endmodule

// File: rtl/time_display_scan.sv
// 8-digit multiplexed 7-segment driver for the clock datapath.
// Snapshots the time once per frame, scans one digit per DWELL_CYCLES slot
// with a leading blank clock against ghosting, and registers the pins.
// Optional: define TIME_DISPLAY_BLINK_EN to blink the field being adjusted.
import time_display_pkg::*;

module time_display_scan #(
  parameter int DWELL_CYCLES      = 4,
  parameter int SEG_ACTIVE_LOW    = 1,
  parameter int BLINK_HALF_PERIOD = 250
) (
  input  logic       CP_1kHz,
  input  logic       _CR,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [3:0] time_display_1,
  input  logic [3:0] time_display_2,
  input  logic       hour_adj,
  input  logic       min_adj,
  output logic [7:0] seg,
  output logic [7:0] dig_sel
);

  localparam int            DW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [2:0]    idx_q, idx_d;
  logic          frame_end;
  snap_t         snap_q;
  logic [7:0]    hr_bcd, min_bcd, sec_bcd;
  logic [3:0]    code;
  logic [6:0]    pat;
  logic [7:0]    seg_q, seg_d, dig_q, dig_d;
  logic          blank_hr, blank_min;

  assign frame_end = (idx_q == DIG_SEC_O) && (dwell_q == DWELL_LAST);

  // Dwell/slot counter next state; slot wraps 7 -> 0 naturally in 3 bits
  always_comb begin
    dwell_d = dwell_q + 1'b1;
    idx_d   = idx_q;
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      idx_d   = idx_q + 3'd1;
    end
  end

  // Scan position registers
  always_ff @(posedge CP_1kHz or negedge _CR) begin
    if (!_CR) begin
      dwell_q <= '0;
      idx_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
    end
  end

  // Capture all inputs together at frame end so a frame never tears
  always_ff @(posedge CP_1kHz or negedge _CR) begin
    if (!_CR)           snap_q <= SNAP_RST;
    else if (frame_end) snap_q <= '{hours: hours, minutes: minutes, seconds: seconds,
                                    td1: time_display_1, td2: time_display_2};
  end

`ifdef TIME_DISPLAY_BLINK_EN
  localparam int BW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;

  logic [BW-1:0] blink_cnt_q;
  logic          phase_on_q, hadj_q, madj_q;

  // Blink half-period counter and phase; starts in the visible phase
  always_ff @(posedge CP_1kHz or negedge _CR) begin
    if (!_CR) begin
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_HALF_PERIOD - 1)) begin
      blink_cnt_q <= '0;
      phase_on_q  <= ~phase_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Adjust flags travel with the rest of the snapshot
  always_ff @(posedge CP_1kHz or negedge _CR) begin
    if (!_CR) begin
      hadj_q <= 1'b0;
      madj_q <= 1'b0;
    end else if (frame_end) begin
      hadj_q <= hour_adj;
      madj_q <= min_adj;
    end
  end

  assign blank_hr  = hadj_q && !phase_on_q;
  assign blank_min = madj_q && !phase_on_q;
`else
  logic unused_blink;
  assign unused_blink = ^{hour_adj, min_adj, (BLINK_HALF_PERIOD > 0)};
  assign blank_hr     = 1'b0;
  assign blank_min    = 1'b0;
`endif

  assign hr_bcd  = bcd2({1'b0, snap_q.hours}, 6'd23);
  assign min_bcd = bcd2(snap_q.minutes, 6'd59);
  assign sec_bcd = bcd2(snap_q.seconds, 6'd59);

  // Pick the display code for the current slot, applying blink blanking
  always_comb begin
    code = CODE_BLANK;
    case (idx_q)
      DIG_TD1:   code = snap_q.td1;
      DIG_TD2:   code = snap_q.td2;
      DIG_HR_T:  code = blank_hr  ? CODE_BLANK : hr_bcd[7:4];
      DIG_HR_O:  code = blank_hr  ? CODE_BLANK : hr_bcd[3:0];
      DIG_MIN_T: code = blank_min ? CODE_BLANK : min_bcd[7:4];
      DIG_MIN_O: code = blank_min ? CODE_BLANK : min_bcd[3:0];
      DIG_SEC_T: code = sec_bcd[7:4];
      DIG_SEC_O: code = sec_bcd[3:0];
      default:   code = CODE_BLANK;
    endcase
  end

  seg7_decode u_dec (
    .code_i (code),
    .pat_o  (pat)
  );

  // Dwell 0 is dark on every slot; otherwise light one digit with separators on 3 and 5
  always_comb begin
    seg_d = '0;
    dig_d = '0;
    if (dwell_q != '0) begin
      dig_d = 8'b1 << idx_q;
      seg_d = {(idx_q == DIG_HR_O) || (idx_q == DIG_MIN_O), pat};
    end
  end

  // Registered, active-high internal outputs
  always_ff @(posedge CP_1kHz or negedge _CR) begin
    if (!_CR) begin
      seg_q <= '0;
      dig_q <= '0;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign seg     = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dig_sel = (SEG_ACTIVE_LOW != 0) ? ~dig_q : dig_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Scoreboard bench for time_display_scan: a cycle-count model predicts the
// pin levels for each clock, queues them, and compares after the edge.
module tb_time_display_scan;

  localparam int D     = 4;
  localparam int HALF  = 250;
  localparam int FRAME = 8 * D;

  logic       clk  = 1'b0;
  logic       cr_n = 1'b1;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic [3:0] td1, td2;
  logic       hour_adj, min_adj;
  logic [7:0] seg, dig_sel;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [$];
  int          tcyc;
  logic [4:0]  s_h;
  logic [5:0]  s_m, s_s;
  logic [3:0]  s_t1, s_t2;
  logic        s_hadj, s_madj;

  time_display_scan #(
    .DWELL_CYCLES      (D),
    .SEG_ACTIVE_LOW    (1),
    .BLINK_HALF_PERIOD (HALF)
  ) dut (
    .CP_1kHz        (clk),
    ._CR            (cr_n),
    .hours          (hours),
    .minutes        (minutes),
    .seconds        (seconds),
    .time_display_1 (td1),
    .time_display_2 (td2),
    .hour_adj       (hour_adj),
    .min_adj        (min_adj),
    .seg            (seg),
    .dig_sel        (dig_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got dig/seg=%04h want %04h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int c);
    case (c)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h73;
     12: return 7'h37; 14: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int code_at(input int ix);
    int h, m, s;
    h = int'(s_h); m = int'(s_m); s = int'(s_s);
    case (ix)
      0: return int'(s_t1);
      1: return int'(s_t2);
      2: return (h > 23) ? 14 : h / 10;
      3: return (h > 23) ? 14 : h % 10;
      4: return (m > 59) ? 14 : m / 10;
      5: return (m > 59) ? 14 : m % 10;
      6: return (s > 59) ? 14 : s / 10;
      default: return (s > 59) ? 14 : s % 10;
    endcase
  endfunction

  task automatic model_reset();
    tcyc = 0;
    s_h = 0; s_m = 0; s_s = 0; s_t1 = 13; s_t2 = 13;
    s_hadj = 0; s_madj = 0;
  endtask

  // One clock: predict, queue, capture model snapshot at frame end, then compare
  task automatic step();
    int dw, ix, c;
    logic [7:0] e_seg, e_dig;
    logic [15:0] want;
    dw = tcyc % D;
    ix = (tcyc / D) % 8;
    e_seg = 8'h00;
    e_dig = 8'h00;
    if (dw != 0) begin
      c = code_at(ix);
`ifdef TIME_DISPLAY_BLINK_EN
      if (((tcyc / HALF) % 2) == 1 &&
          ((s_hadj && (ix == 2 || ix == 3)) || (s_madj && (ix == 4 || ix == 5))))
        c = 13;
`endif
      e_seg = {(ix == 3 || ix == 5), pat(c)};
      e_dig = 8'h01 << ix;
    end
    exp_q.push_back(~{e_dig, e_seg});
    if (tcyc % FRAME == FRAME - 1) begin
      s_h = hours; s_m = minutes; s_s = seconds; s_t1 = td1; s_t2 = td2;
      s_hadj = hour_adj; s_madj = min_adj;
    end
    tcyc++;
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    chk($sformatf("slot%0d_dw%0d_t%0d", ix, dw, tcyc - 1), {dig_sel, seg}, want);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    hours = 5'd13; minutes = 6'd5; seconds = 6'd9; td1 = 4'd13; td2 = 4'd13;
    hour_adj = 1'b0; min_adj = 1'b0;
    #1 cr_n = 1'b0;
    #11;
    chk("reset_pins", {dig_sel, seg}, 16'hFFFF);
    @(posedge clk); #1;
    cr_n = 1'b1;
    model_reset();

    // Reset snapshot frame, then 13:05:09
    run(2 * FRAME);

    // 12h mode: P M 12
    td1 = 4'd11; td2 = 4'd12; hours = 5'd12;
    run(2 * FRAME);

    // Seconds change mid-frame must not tear
    seconds = 6'd8;
    run(FRAME);
    run(4 * D + 1);
    seconds = 6'd9;
    run(2 * FRAME);

    // Out-of-range hours/minutes show dashes
    hours = 5'd25; minutes = 6'd60;
    run(FRAME + 4 * D);

    // Asynchronous reset mid-frame
    #2 cr_n = 1'b0;
    #1 chk("async_reset", {dig_sel, seg}, 16'hFFFF);
    @(posedge clk); #1;
    chk("reset_hold", {dig_sel, seg}, 16'hFFFF);
    cr_n = 1'b1;
    model_reset();
    hours = 5'd7; minutes = 6'd42; seconds = 6'd59; td1 = 4'd10; td2 = 4'd12;
    run(2 * FRAME);

    // Hour adjust: blinks only when the blink feature is built in
    hour_adj = 1'b1;
    run(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
